// File: rtl/fnd_sum_display.sv
// Captures a 5-bit adder result, converts it to BCD by sequential double-dabble and
// drives a 4-digit common-anode multiplexed 7-seg display. Option: LEADING_ZERO_BLANK_EN.
module fnd_sum_display #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic [3:0] i_sum,
  input  logic       i_carry,
  output logic       o_busy,
  output logic [3:0] o_fnd_com,
  output logic [7:0] o_fnd_font
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t         r_state;
  logic [12:0]    r_shift;   // {tens, ones, operand}
  logic [2:0]     r_iter;
  logic [3:0]     r_tens;
  logic [3:0]     r_ones;
  logic           r_busy;
  logic [CW-1:0]  r_scan_cnt;
  logic [1:0]     r_digit_idx;

  logic [12:0]    w_adj;
  logic [12:0]    w_next;
  logic [3:0]     w_com;
  logic [7:0]     w_font;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble, then shift the whole register left.
  always_comb begin
    w_adj = r_shift;
    if (r_shift[8:5] >= 4'd5)  w_adj[8:5]  = r_shift[8:5]  + 4'd3;
    if (r_shift[12:9] >= 4'd5) w_adj[12:9] = r_shift[12:9] + 4'd3;
    w_next = {w_adj[11:0], 1'b0};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_iter  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_shift <= {8'h00, i_carry, i_sum};
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_shift <= w_next;
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd4) begin
            r_tens  <= w_next[12:9];
            r_ones  <= w_next[8:5];
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running digit scan, independent of conversion activity.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + CW'(1);
    end
  end

  always_comb begin
    w_com  = 4'b1111;
    w_font = 8'hFF;
    case (r_digit_idx)
      2'd0: begin
        w_com  = 4'b1110;
        w_font = seg_of(r_ones);
      end
      2'd1: begin
        w_com  = 4'b1101;
`ifdef LEADING_ZERO_BLANK_EN
        w_font = (r_tens == 4'd0) ? 8'hFF : seg_of(r_tens);
`else
        w_font = seg_of(r_tens);
`endif
      end
      2'd2: w_com = 4'b1011;
      default: w_com = 4'b0111;
    endcase
  end

  assign o_busy     = r_busy;
  assign o_fnd_com  = w_com;
  assign o_fnd_font = w_font;

endmodule

// File: tb/tb_fnd_sum_display.sv
// Directed bench for fnd_sum_display (SCAN_DIV=4) with a queue of expected display values.
module tb_fnd_sum_display;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [3:0] i_sum = 4'h0;
  logic       i_carry = 1'b0;
  logic       o_busy;
  logic [3:0] o_fnd_com;
  logic [7:0] o_fnd_font;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         val;
    logic [7:0] tens;
    logic [7:0] ones;
  } exp_t;
  exp_t sb[$];

  fnd_sum_display #(.SCAN_DIV(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_sum(i_sum),
    .i_carry(i_carry), .o_busy(o_busy), .o_fnd_com(o_fnd_com), .o_fnd_font(o_fnd_font)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] font_of(input int d);
    logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  function automatic logic [7:0] tens_font(input int v);
`ifdef LEADING_ZERO_BLANK_EN
    if (v / 10 == 0) return 8'hFF;
`endif
    return font_of(v / 10);
  endfunction

  task automatic push_exp(input int v);
    exp_t e;
    e.val = v; e.tens = tens_font(v); e.ones = font_of(v % 10);
    sb.push_back(e);
  endtask

  // Observe one full scan and compare all four slots with the oldest expectation.
  task automatic check_display(input string tag);
    exp_t e;
    logic [7:0] f [4];
    logic [3:0] seen = 4'b0000;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    for (int n = 0; n < 40 && seen != 4'b1111; n++) begin
      case (o_fnd_com)
        4'b1110: begin f[0] = o_fnd_font; seen[0] = 1'b1; end
        4'b1101: begin f[1] = o_fnd_font; seen[1] = 1'b1; end
        4'b1011: begin f[2] = o_fnd_font; seen[2] = 1'b1; end
        4'b0111: begin f[3] = o_fnd_font; seen[3] = 1'b1; end
        default: chk({tag, "_com_onehot"}, {28'd0, o_fnd_com}, 32'hE);
      endcase
      tick();
    end
    chk({tag, "_slots_seen"}, {28'd0, seen}, 32'hF);
    if (seen == 4'b1111) begin
      chk($sformatf("%s_ones_v%0d", tag, e.val), {24'd0, f[0]}, {24'd0, e.ones});
      chk($sformatf("%s_tens_v%0d", tag, e.val), {24'd0, f[1]}, {24'd0, e.tens});
      chk({tag, "_blank2"}, {24'd0, f[2]}, 32'hFF);
      chk({tag, "_blank3"}, {24'd0, f[3]}, 32'hFF);
    end
  endtask

  // Strobe a value and return how many cycles o_busy stayed high.
  task automatic strobe(input int v, output int busy_len);
    i_carry = v[4]; i_sum = v[3:0]; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    busy_len = 0;
    while (o_busy === 1'b1 && busy_len < 20) begin
      busy_len++;
      tick();
    end
  endtask

  initial begin
    int len;

    // Reset, then release with no input.
    tick(); tick();
    i_reset = 1'b0;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_com", {28'd0, o_fnd_com}, 32'hE);
    chk("rst_font", {24'd0, o_fnd_font}, 32'hC0);
    tick(); tick(); tick();
    chk("scan_hold3", {28'd0, o_fnd_com}, 32'hE);
    tick();
    chk("scan_adv4", {28'd0, o_fnd_com}, 32'hD);
    chk("rst_tens", {24'd0, o_fnd_font}, {24'd0, tens_font(0)});

    // Maximum result 31: exact busy length.
    push_exp(31);
    strobe(31, len);
    chk("busy_len_31", len, 5);
    check_display("max31");

    push_exp(9);
    strobe(9, len);
    chk("busy_len_9", len, 5);
    check_display("v9");

    // Second strobe while busy is ignored.
    push_exp(10);
    i_carry = 1'b0; i_sum = 4'hA; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("ign_busy1", {31'd0, o_busy}, 32'd1);
    tick();
    i_carry = 1'b1; i_sum = 4'hE; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    len = 0;
    while (o_busy === 1'b1 && len < 20) begin len++; tick(); end
    chk("ign_busy_len", len, 3);
    tick(); tick();
    chk("ign_no_requeue", {31'd0, o_busy}, 32'd0);
    check_display("ignore");

    // Reset mid-conversion aborts and clears display.
    i_carry = 1'b1; i_sum = 4'h7; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick();
    i_reset = 1'b1;
    tick();
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_com", {28'd0, o_fnd_com}, 32'hE);
    chk("abort_font", {24'd0, o_fnd_font}, 32'hC0);
    i_reset = 1'b0;
    push_exp(0);
    check_display("abort");

    // Strobe coincident with reset loses.
    i_reset = 1'b1; i_carry = 1'b1; i_sum = 4'h5; i_valid = 1'b1;
    tick();
    i_reset = 1'b0; i_valid = 1'b0;
    chk("rst_wins_busy", {31'd0, o_busy}, 32'd0);
    tick();
    chk("rst_wins_busy2", {31'd0, o_busy}, 32'd0);

    // Full operand sweep.
    for (int v = 0; v < 32; v++) begin
      push_exp(v);
      strobe(v, len);
      chk($sformatf("sweep_len_%0d", v), len, 5);
      check_display("sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
